// File: rtl/acc_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : acc_shift_reg
// Brief    : Multi-mode accumulator register (load/shift/rotate/inc/dec)
//            with true/complement outputs, carry and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module acc_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_cmp,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_INC  = 3'b110;
    localparam logic [2:0] c_MODE_DEC  = 3'b111;

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_carry_nxt;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;

    // One extra bit on each side: its MSB is the carry-out (inc) or borrow (dec).
    assign w_inc = {1'b0, r_q} + (WIDTH+1)'(1);
    assign w_dec = {1'b0, r_q} - (WIDTH+1)'(1);

    always_comb begin
        w_q_nxt     = r_q;
        w_carry_nxt = r_carry;
        if (en) begin
            case (mode)
                c_MODE_HOLD: begin
                    w_q_nxt     = r_q;
                    w_carry_nxt = r_carry;
                end
                c_MODE_LOAD: w_q_nxt = d;
                c_MODE_SHL: begin
                    w_q_nxt     = {r_q[WIDTH-2:0], ser_in};
                    w_carry_nxt = r_q[WIDTH-1];
                end
                c_MODE_SHR: begin
                    w_q_nxt     = {ser_in, r_q[WIDTH-1:1]};
                    w_carry_nxt = r_q[0];
                end
                c_MODE_ROL: begin
                    w_q_nxt     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_carry_nxt = r_q[WIDTH-1];
                end
                c_MODE_ROR: begin
                    w_q_nxt     = {r_q[0], r_q[WIDTH-1:1]};
                    w_carry_nxt = r_q[0];
                end
                c_MODE_INC: begin
                    w_q_nxt     = w_inc[WIDTH-1:0];
                    w_carry_nxt = w_inc[WIDTH];
                end
                c_MODE_DEC: begin
                    w_q_nxt     = w_dec[WIDTH-1:0];
                    w_carry_nxt = w_dec[WIDTH];
                end
                default: begin
                    w_q_nxt     = r_q;
                    w_carry_nxt = r_carry;
                end
            endcase
        end
    end

    // clr outranks set; both outrank any operation in flight.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q     <= CLR_VAL;
            r_carry <= 1'b0;
        end else if (!set) begin
            r_q     <= SET_VAL;
            r_carry <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign q     = r_q;
    assign q_cmp = ~r_q;
    assign carry = r_carry;
    assign zero  = (r_q == {WIDTH{1'b0}});

endmodule
`default_nettype wire

// File: tb/tb_acc_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_shift_reg
// Brief    : Self-checking bench for acc_shift_reg (directed + random vs model)
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_shift_reg;

    logic       clk;
    logic       clr, set, en, ser_in;
    logic [2:0] mode;
    logic [7:0] d, q, q_cmp;
    logic       carry, zero;

    logic        p_clr, p_set, p_en, p_ser;
    logic [2:0]  p_mode;
    logic [3:0]  d4, q4, q4_cmp;
    logic [15:0] d16, q16, q16_cmp;
    logic        c4, z4, c16, z16;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state for the 8-bit instance, kept as plain integers.
    int m_q = 0;
    int m_c = 0;

    acc_shift_reg #(.WIDTH(8)) u_dut (
        .clk(clk), .clr(clr), .set(set), .en(en), .mode(mode), .d(d),
        .ser_in(ser_in), .q(q), .q_cmp(q_cmp), .carry(carry), .zero(zero)
    );

    acc_shift_reg #(.WIDTH(4), .CLR_VAL(4'h1), .SET_VAL(4'h0)) u_w4 (
        .clk(clk), .clr(p_clr), .set(p_set), .en(p_en), .mode(p_mode), .d(d4),
        .ser_in(p_ser), .q(q4), .q_cmp(q4_cmp), .carry(c4), .zero(z4)
    );

    acc_shift_reg #(.WIDTH(16), .CLR_VAL(16'h0001), .SET_VAL(16'h0000)) u_w16 (
        .clk(clk), .clr(p_clr), .set(p_set), .en(p_en), .mode(p_mode), .d(d16),
        .ser_in(p_ser), .q(q16), .q_cmp(q16_cmp), .carry(c16), .zero(z16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle on the 8-bit instance, advance the model, sample #1 after the edge.
    task automatic drive(input logic c, input logic s, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic si);
        clr = c; set = s; en = e; mode = m; d = dd; ser_in = si;
        if (!c) begin
            m_q = 0; m_c = 0;
        end else if (!s) begin
            m_q = 255; m_c = 0;
        end else if (e) begin
            case (m)
                3'd1: m_q = int'(dd);
                3'd2: begin m_c = (m_q >> 7) & 1; m_q = ((m_q << 1) | int'(si)) & 255; end
                3'd3: begin m_c = m_q & 1; m_q = (m_q >> 1) | (int'(si) << 7); end
                3'd4: begin m_c = (m_q >> 7) & 1; m_q = ((m_q << 1) | (m_q >> 7)) & 255; end
                3'd5: begin m_c = m_q & 1; m_q = (m_q >> 1) | ((m_q & 1) << 7); end
                3'd6: begin m_q = m_q + 1; m_c = m_q >> 8; m_q = m_q & 255; end
                3'd7: begin m_c = (m_q == 0) ? 1 : 0; m_q = (m_q + 255) & 255; end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_p(input logic c, input logic s, input logic e, input logic [2:0] m,
                           input logic [15:0] dd);
        p_clr = c; p_set = s; p_en = e; p_mode = m; d4 = dd[3:0]; d16 = dd; p_ser = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 8'h77, 1'b1);
        n_checks++; if ({q, q_cmp, carry, zero} !== {8'h00, 8'hFF, 1'b0, 1'b1}) begin
            n_fails++; $display("FAIL reset_clr: got q=%h qc=%h c=%b z=%b want 00 ff 0 1", q, q_cmp, carry, zero); end
        drive(1'b1, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
        n_checks++; if ({q, q_cmp, carry, zero} !== {8'hFF, 8'h00, 1'b0, 1'b0}) begin
            n_fails++; $display("FAIL preset: got q=%h qc=%h c=%b z=%b want ff 00 0 0", q, q_cmp, carry, zero); end
        drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h5A, 1'b0);
        n_checks++; if (q !== 8'h00) begin
            n_fails++; $display("FAIL clr_over_set: got q=%h want 00", q); end
    endtask

    task automatic test_load_hold;
        drive(1'b1, 1'b1, 1'b1, 3'd1, 8'hA5, 1'b0);
        n_checks++; if ({q, q_cmp, carry} !== {8'hA5, 8'h5A, 1'b0}) begin
            n_fails++; $display("FAIL load: got q=%h qc=%h c=%b want a5 5a 0", q, q_cmp, carry); end
        drive(1'b1, 1'b1, 1'b0, 3'd1, 8'h3C, 1'b0);
        n_checks++; if (q !== 8'hA5) begin
            n_fails++; $display("FAIL en_low_hold: got q=%h want a5", q); end
        drive(1'b1, 1'b1, 1'b1, 3'd0, 8'h3C, 1'b0);
        n_checks++; if (q !== 8'hA5) begin
            n_fails++; $display("FAIL mode_hold: got q=%h want a5", q); end
    endtask

    task automatic test_shift_chain;
        drive(1'b1, 1'b1, 1'b1, 3'd1, 8'h81, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 3'd2, 8'h00, 1'b0);
        n_checks++; if ({q, carry} !== {8'h02, 1'b1}) begin
            n_fails++; $display("FAIL shl: got q=%h c=%b want 02 1", q, carry); end
        drive(1'b1, 1'b1, 1'b1, 3'd3, 8'h00, 1'b1);
        n_checks++; if ({q, carry} !== {8'h81, 1'b0}) begin
            n_fails++; $display("FAIL shr: got q=%h c=%b want 81 0", q, carry); end
        drive(1'b1, 1'b1, 1'b1, 3'd5, 8'h00, 1'b0);
        n_checks++; if ({q, carry} !== {8'hC0, 1'b1}) begin
            n_fails++; $display("FAIL ror: got q=%h c=%b want c0 1", q, carry); end
        drive(1'b1, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0);
        n_checks++; if ({q, carry} !== {8'h81, 1'b1}) begin
            n_fails++; $display("FAIL rol: got q=%h c=%b want 81 1", q, carry); end
    endtask

    task automatic test_inc_dec_wrap;
        drive(1'b1, 1'b1, 1'b1, 3'd1, 8'hFE, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 3'd6, 8'h00, 1'b0);
        n_checks++; if ({q, carry} !== {8'hFF, 1'b0}) begin
            n_fails++; $display("FAIL inc1: got q=%h c=%b want ff 0", q, carry); end
        drive(1'b1, 1'b1, 1'b1, 3'd6, 8'h00, 1'b0);
        n_checks++; if ({q, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
            n_fails++; $display("FAIL inc_wrap: got q=%h c=%b z=%b want 00 1 1", q, carry, zero); end
        drive(1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0);
        n_checks++; if ({q, carry, zero} !== {8'hFF, 1'b1, 1'b0}) begin
            n_fails++; $display("FAIL dec_wrap: got q=%h c=%b z=%b want ff 1 0", q, carry, zero); end
        drive(1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0);
        n_checks++; if ({q, carry} !== {8'hFE, 1'b0}) begin
            n_fails++; $display("FAIL dec1: got q=%h c=%b want fe 0", q, carry); end
    endtask

    task automatic test_mid_reset;
        drive(1'b1, 1'b1, 1'b1, 3'd1, 8'h55, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 8'h00, 1'b1);
        n_checks++; if ({q, carry} !== {8'h00, 1'b0}) begin
            n_fails++; $display("FAIL mid_clr: got q=%h c=%b want 00 0", q, carry); end
        drive(1'b1, 1'b1, 1'b1, 3'd2, 8'h00, 1'b1);
        n_checks++; if ({q, carry} !== {8'h01, 1'b0}) begin
            n_fails++; $display("FAIL resume_shl: got q=%h c=%b want 01 0", q, carry); end
    endtask

    task automatic test_param_sweep;
        drive_p(1'b0, 1'b1, 1'b1, 3'd6, 16'h0000);
        n_checks++; if ({q4, q4_cmp, c4, z4} !== {4'h1, 4'hE, 1'b0, 1'b0}) begin
            n_fails++; $display("FAIL w4_clr: got q=%h qc=%h c=%b z=%b want 1 e 0 0", q4, q4_cmp, c4, z4); end
        n_checks++; if ({q16, q16_cmp, c16, z16} !== {16'h0001, 16'hFFFE, 1'b0, 1'b0}) begin
            n_fails++; $display("FAIL w16_clr: got q=%h qc=%h c=%b z=%b want 0001 fffe 0 0", q16, q16_cmp, c16, z16); end
        drive_p(1'b1, 1'b0, 1'b1, 3'd6, 16'h0000);
        n_checks++; if ({q4, q4_cmp, z4, q16, q16_cmp, z16} !== {4'h0, 4'hF, 1'b1, 16'h0000, 16'hFFFF, 1'b1}) begin
            n_fails++; $display("FAIL sweep_set: got q4=%h qc4=%h z4=%b q16=%h qc16=%h z16=%b", q4, q4_cmp, z4, q16, q16_cmp, z16); end
        drive_p(1'b1, 1'b1, 1'b1, 3'd1, 16'hFFFF);
        drive_p(1'b1, 1'b1, 1'b1, 3'd6, 16'h0000);
        n_checks++; if ({q4, q4_cmp, c4, z4} !== {4'h0, 4'hF, 1'b1, 1'b1}) begin
            n_fails++; $display("FAIL w4_inc_wrap: got q=%h qc=%h c=%b z=%b want 0 f 1 1", q4, q4_cmp, c4, z4); end
        n_checks++; if ({q16, q16_cmp, c16, z16} !== {16'h0000, 16'hFFFF, 1'b1, 1'b1}) begin
            n_fails++; $display("FAIL w16_inc_wrap: got q=%h qc=%h c=%b z=%b want 0000 ffff 1 1", q16, q16_cmp, c16, z16); end
    endtask

    task automatic test_random;
        logic c, s, e, si;
        logic [2:0] m;
        logic [7:0] dd;
        drive(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            c  = ($urandom_range(0, 63) != 0);
            s  = ($urandom_range(0, 63) != 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 3'($urandom_range(0, 7));
            dd = 8'($urandom);
            si = 1'($urandom);
            drive(c, s, e, m, dd, si);
            n_checks++;
            if ({q, q_cmp, carry, zero} !== {8'(m_q), ~8'(m_q), 1'(m_c), (m_q == 0)}) begin
                n_fails++;
                $display("FAIL random[%0d]: got q=%h qc=%h c=%b z=%b want q=%h c=%0d", i, q, q_cmp, carry, zero, 8'(m_q), m_c);
            end
        end
    endtask

    initial begin
        clr = 1'b0; set = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; ser_in = 1'b0;
        p_clr = 1'b0; p_set = 1'b1; p_en = 1'b0; p_mode = 3'd0; d4 = 4'h0; d16 = 16'h0; p_ser = 1'b0;
        #2;
        test_reset();
        test_load_hold();
        test_shift_chain();
        test_inc_dec_wrap();
        test_mid_reset();
        test_param_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
